// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam bit P_CPU = 1'b0;
  localparam bit P_DMA = 1'b1;

  // Wait-counter width; never below one bit so MEM_LAT = 1 still gets a flop.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational 2-way picker: round-robin by default, fixed CPU priority
// when MEM_ARB_CPU_PRIO_EN is defined.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt_c
);

`ifdef MEM_ARB_CPU_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    gnt_c = 2'b00;
    if (req[P_CPU])      gnt_c[P_CPU] = 1'b1;
    else if (req[P_DMA]) gnt_c[P_DMA] = 1'b1;
  end
`else
  // On a tie the port that did not win last time is served.
  always_comb begin
    gnt_c = 2'b00;
    if (req[P_CPU] && req[P_DMA]) gnt_c[~last] = 1'b1;
    else                          gnt_c = req;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between the CPU (port 0) and DMA (port 1).
// Define MEM_ARB_CPU_PRIO_EN for fixed CPU priority instead of round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] adr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] adr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [1:0]    gnt,
  output logic          busy,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic          MemRead,
  output logic          MemWrite,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned   CW       = clog2(MEM_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          busy_q, busy_d;
  logic [1:0]    pick_c;

  mem_arb_rr_pick u_pick (
    .req   ({req1, req0}),
    .last  (last_q),
    .gnt_c (pick_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|pick_c) begin
          state_d = ACCESS;
          gnt_d   = pick_c;
          cnt_d   = CNT_LOAD;
          if (pick_c[P_DMA]) begin
            we_d    = we1;
            adr_d   = adr1;
            wdata_d = wdata1;
          end else begin
            we_d    = we0;
            adr_d   = adr0;
            wdata_d = wdata0;
          end
          rd_d = ~we_d;
          wr_d = we_d;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ack0_d  = gnt_q[P_CPU];
          ack1_d  = gnt_q[P_DMA];
          if (!we_q) rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        last_d  = gnt_q[P_DMA];
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign mem_adr   = adr_q;
  assign mem_wdata = wdata_q;
  assign MemRead   = rd_q;
  assign MemWrite  = wr_q;

endmodule
